// File: rtl/pu_lut_ctrl_pkg.sv
// Shared definitions for the pu_lut sequencer: state encoding and width helpers.
package pu_lut_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_WRITE = ST_WRITE,
      S_READ  = ST_READ,
      S_HOLD  = ST_HOLD
   } state_t;

   // Width of an argument-count field able to hold 0..max_args
   function automatic int nw_f(input int max_args);
      return $clog2(max_args + 1);
   endfunction

   // Width of the argument index counter (0..max_args-1), never below 1
   function automatic int kw_f(input int max_args);
      return (max_args > 1) ? $clog2(max_args) : 1;
   endfunction

endpackage

// File: rtl/pu_lut_ctrl_if.sv
// Request/result handshake bus plus the LUT-facing strobes of the sequencer.
interface pu_lut_ctrl_if
   import pu_lut_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ATTR_WIDTH   = 4,
   parameter int SEL_WIDTH    = 4,
   parameter int MAX_NUM_ARGS = 2
);
   localparam int NW = nw_f(MAX_NUM_ARGS);

   // Request side
   logic                               req_valid;
   logic                               req_ready;
   logic [SEL_WIDTH-1:0]               req_sel;
   logic [NW-1:0]                      req_nargs;
   logic [MAX_NUM_ARGS*DATA_WIDTH-1:0] req_args;
   logic [ATTR_WIDTH-1:0]              req_attr;

   // LUT side
   logic                               lut_signal_wr;
   logic                               lut_signal_oe;
   logic [SEL_WIDTH-1:0]               lut_signal_sel;
   logic [DATA_WIDTH-1:0]              lut_data_in;
   logic [ATTR_WIDTH-1:0]              lut_attr_in;
   logic [DATA_WIDTH-1:0]              lut_data_out;
   logic [ATTR_WIDTH-1:0]              lut_attr_out;

   // Result side
   logic                               res_valid;
   logic                               res_ready;
   logic [DATA_WIDTH-1:0]              res_data;
   logic [ATTR_WIDTH-1:0]              res_attr;
   logic                               res_err;

   // The sequencer itself
   modport slave (
      input  req_valid, req_sel, req_nargs, req_args, req_attr,
      output req_ready,
      output lut_signal_wr, lut_signal_oe, lut_signal_sel, lut_data_in, lut_attr_in,
      input  lut_data_out, lut_attr_out,
      output res_valid, res_data, res_attr, res_err,
      input  res_ready
   );

   // The environment: requester, result consumer and the LUT
   modport master (
      output req_valid, req_sel, req_nargs, req_args, req_attr,
      input  req_ready,
      input  lut_signal_wr, lut_signal_oe, lut_signal_sel, lut_data_in, lut_attr_in,
      output lut_data_out, lut_attr_out,
      input  res_valid, res_data, res_attr, res_err,
      output res_ready
   );

endinterface

// File: rtl/pu_lut_ctrl.sv
// Sequencer in front of pu_lut: serialises request args into the LUT write
// port (always MAX_NUM_ARGS writes so the LUT pointer wraps to 0), strobes
// the read, and holds the result until the consumer accepts it.
module pu_lut_ctrl
   import pu_lut_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ATTR_WIDTH   = 4,
   parameter int SEL_WIDTH    = 4,
   parameter int MAX_NUM_ARGS = 2
) (
   input  logic         clk,
   input  logic         rst,
   pu_lut_ctrl_if.slave bus
);

   localparam int            NW        = nw_f(MAX_NUM_ARGS);
   localparam int            KW        = kw_f(MAX_NUM_ARGS);
   localparam logic [NW-1:0] NARGS_MAX = NW'(MAX_NUM_ARGS);
   localparam logic [KW-1:0] K_LAST    = KW'(MAX_NUM_ARGS - 1);

   state_t                state_q, state_d;
   logic [KW-1:0]         k_q, k_d;
   logic                  err_q, err_d;
   logic [SEL_WIDTH-1:0]  sel_q;
   logic [ATTR_WIDTH-1:0] attr_q;
   logic [DATA_WIDTH-1:0] args_q [MAX_NUM_ARGS];
   logic [DATA_WIDTH-1:0] args_d [MAX_NUM_ARGS];
   logic [NW-1:0]         nargs_eff;
   logic [DATA_WIDTH-1:0] res_data_q;
   logic [ATTR_WIDTH-1:0] res_attr_q;
   logic                  res_err_q;
   logic                  accept;

   assign accept = (state_q == S_IDLE) && bus.req_valid;

   // Qualify incoming args: zero unused slots and flag malformed requests
   always_comb begin
      err_d     = (bus.req_nargs > NARGS_MAX);
      nargs_eff = err_d ? NARGS_MAX : bus.req_nargs;
      for (int i = 0; i < MAX_NUM_ARGS; i++) begin
         args_d[i] = '0;
         if (NW'(i) < nargs_eff) begin
            args_d[i] = bus.req_args[i*DATA_WIDTH +: DATA_WIDTH];
            // The LUT only consumes bit 0; anything above it is a caller bug
            if (|args_d[i][DATA_WIDTH-1:1]) begin
               err_d = 1'b1;
            end
         end
      end
   end

   // Next-state logic and argument index sequencing
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               state_d = S_WRITE;
               k_d     = '0;
            end
         end
         S_WRITE: begin
            if (k_q == K_LAST) begin
               state_d = S_READ;
               k_d     = '0;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_READ: begin
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (bus.res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the current state; LUT strobes are zero when unused
   always_comb begin
      bus.req_ready      = (state_q == S_IDLE);
      bus.lut_signal_wr  = (state_q == S_WRITE);
      bus.lut_signal_oe  = (state_q == S_READ);
      bus.lut_signal_sel = (state_q == S_IDLE) ? '0 : sel_q;
      bus.lut_data_in    = '0;
      bus.lut_attr_in    = '0;
      if (state_q == S_WRITE) begin
         bus.lut_data_in = args_q[k_q];
      end
      if (state_q == S_READ) begin
         bus.lut_attr_in = attr_q;
      end
      bus.res_valid = (state_q == S_HOLD);
      bus.res_data  = res_data_q;
      bus.res_attr  = res_attr_q;
      bus.res_err   = res_err_q;
   end

   // Control state, error flag and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         err_q      <= 1'b0;
         res_data_q <= '0;
         res_attr_q <= '0;
         res_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         if (accept) begin
            err_q <= err_d;
         end
         // The LUT read path is combinational, so capture it in the READ cycle
         if (state_q == S_READ) begin
            res_data_q <= bus.lut_data_out;
            res_attr_q <= bus.lut_attr_out;
            res_err_q  <= err_q;
         end
      end
   end

   // Operand latch; only observed through state-gated outputs, so no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         sel_q  <= bus.req_sel;
         attr_q <= bus.req_attr;
         for (int i = 0; i < MAX_NUM_ARGS; i++) begin
            args_q[i] <= args_d[i];
         end
      end
   end

endmodule

// File: tb/tb_pu_lut_ctrl.sv
// Directed bench for pu_lut_ctrl driving a small behavioural pu_lut
// (sel 0 = AND, sel 1 = XOR of the bit-0 arguments).
module tb_pu_lut_ctrl;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int SW = 4;
   localparam int MA = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pu_lut_ctrl_if #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .SEL_WIDTH(SW), .MAX_NUM_ARGS(MA)) bus ();

   pu_lut_ctrl #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .SEL_WIDTH(SW), .MAX_NUM_ARGS(MA)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural LUT: modulo argument pointer, combinational read
   logic lut_arg [MA];
   int   ptr = 0;

   always @(posedge clk) begin
      if (bus.lut_signal_wr) begin
         lut_arg[ptr] <= bus.lut_data_in[0];
         ptr          <= (ptr + 1) % MA;
      end
   end

   always_comb begin
      bus.lut_data_out = '0;
      bus.lut_attr_out = '0;
      if (bus.lut_signal_oe) begin
         bus.lut_attr_out = bus.lut_attr_in;
         if (bus.lut_signal_sel == 4'd0) bus.lut_data_out[0] = lut_arg[0] & lut_arg[1];
         else if (bus.lut_signal_sel == 4'd1) bus.lut_data_out[0] = lut_arg[0] ^ lut_arg[1];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request and check every cycle through to the first HOLD cycle
   task automatic run_op(input string tag, input logic [3:0] sel, input logic [1:0] nargs,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [3:0] attr,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] res, input logic err, output int acc_cyc);
      int waits = 0;
      bus.req_valid = 1'b1;
      bus.req_sel   = sel;
      bus.req_nargs = nargs;
      bus.req_args  = {a1, a0};
      bus.req_attr  = attr;
      while (bus.req_ready !== 1'b1 && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      chk({tag, " accept"}, bus.req_ready, 1'b1);
      @(posedge clk);
      #1 acc_cyc = cyc;
      @(negedge clk);
      // Scrambled inputs after acceptance must not matter
      bus.req_valid = 1'b0;
      bus.req_sel   = '1;
      bus.req_nargs = '0;
      bus.req_args  = '1;
      bus.req_attr  = '1;
      chk({tag, " wr1"}, bus.lut_signal_wr, 1'b1);
      chk({tag, " din1"}, bus.lut_data_in, w0);
      chk({tag, " sel1"}, bus.lut_signal_sel, sel);
      chk({tag, " rdy1"}, bus.req_ready, 1'b0);
      @(negedge clk);
      chk({tag, " wr2"}, bus.lut_signal_wr, 1'b1);
      chk({tag, " din2"}, bus.lut_data_in, w1);
      @(negedge clk);
      chk({tag, " oe3"}, bus.lut_signal_oe, 1'b1);
      chk({tag, " wr3"}, bus.lut_signal_wr, 1'b0);
      chk({tag, " ain3"}, bus.lut_attr_in, attr);
      chk({tag, " din3"}, bus.lut_data_in, 32'd0);
      @(negedge clk);
      chk({tag, " rvld"}, bus.res_valid, 1'b1);
      chk({tag, " rdata"}, bus.res_data, res);
      chk({tag, " rattr"}, bus.res_attr, attr);
      chk({tag, " rerr"}, bus.res_err, err);
      chk({tag, " rdy4"}, bus.req_ready, 1'b0);
      chk({tag, " oe4"}, bus.lut_signal_oe, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_sel   = '0;
      bus.req_nargs = '0;
      bus.req_args  = '0;
      bus.req_attr  = '0;
      bus.res_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst ready", bus.req_ready, 1'b1);
      chk("rst rvld", bus.res_valid, 1'b0);
      chk("rst rdata", bus.res_data, 32'd0);
      chk("rst rattr", bus.res_attr, 4'd0);
      chk("rst rerr", bus.res_err, 1'b0);
      chk("rst wr", bus.lut_signal_wr, 1'b0);
      chk("rst oe", bus.lut_signal_oe, 1'b0);
      chk("rst sel", bus.lut_signal_sel, 4'd0);
      chk("rst din", bus.lut_data_in, 32'd0);
      chk("rst ain", bus.lut_attr_in, 4'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle ready", bus.req_ready, 1'b1);

      run_op("and11", 4'd0, 2'd2, 32'd1, 32'd1, 4'd5, 32'd1, 32'd1, 32'd1, 1'b0, t0);
      run_op("xor10", 4'd1, 2'd2, 32'd1, 32'd0, 4'd3, 32'd1, 32'd0, 32'd1, 1'b0, t1);
      run_op("xor11", 4'd1, 2'd2, 32'd1, 32'd1, 4'd7, 32'd1, 32'd1, 32'd0, 1'b0, t2);
      chk("b2b gap", t2 - t1, MA + 3);
      run_op("n1", 4'd0, 2'd1, 32'd1, 32'd1, 4'd2, 32'd1, 32'd0, 32'd0, 1'b0, t0);
      run_op("err_hi", 4'd0, 2'd2, 32'd3, 32'd1, 4'd4, 32'd3, 32'd1, 32'd1, 1'b1, t0);
      run_op("err_n3", 4'd0, 2'd3, 32'd1, 32'd1, 4'd6, 32'd1, 32'd1, 32'd1, 1'b1, t0);
      run_op("n0", 4'd1, 2'd0, 32'd1, 32'd1, 4'd8, 32'd0, 32'd0, 32'd0, 1'b0, t0);
      run_op("unused_hi", 4'd0, 2'd1, 32'd1, 32'd6, 4'd1, 32'd1, 32'd0, 32'd0, 1'b0, t0);

      // Let the last op leave HOLD before applying backpressure
      @(negedge clk);
      bus.res_ready = 1'b0;
      run_op("bp", 4'd1, 2'd2, 32'd0, 32'd1, 4'd9, 32'd0, 32'd1, 32'd1, 1'b0, t0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp hold rvld", bus.res_valid, 1'b1);
         chk("bp hold rdata", bus.res_data, 32'd1);
         chk("bp hold rattr", bus.res_attr, 4'd9);
         chk("bp hold rdy", bus.req_ready, 1'b0);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      chk("bp exit rvld", bus.res_valid, 1'b0);
      chk("bp exit rdy", bus.req_ready, 1'b1);
      chk("bp persist rdata", bus.res_data, 32'd1);
      chk("bp persist rattr", bus.res_attr, 4'd9);

      // Asynchronous reset in the middle of the write phase
      bus.req_valid = 1'b1;
      bus.req_sel   = 4'd1;
      bus.req_nargs = 2'd2;
      bus.req_args  = {32'd1, 32'd1};
      bus.req_attr  = 4'd3;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("mid wr", bus.lut_signal_wr, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid rst wr", bus.lut_signal_wr, 1'b0);
      chk("mid rst din", bus.lut_data_in, 32'd0);
      chk("mid rst sel", bus.lut_signal_sel, 4'd0);
      chk("mid rst rdy", bus.req_ready, 1'b1);
      chk("mid rst rdata", bus.res_data, 32'd0);
      chk("mid rst rattr", bus.res_attr, 4'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
